// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between the core's load/store path
// (master) and the data-memory responder (slave). Signal suffixes are named
// from the responder's point of view.
//   req_*  : request channel, valid/ready handshake, driven by the master
//   rsp_*  : response channel, valid/ready handshake, driven by the slave
interface dmem_responder_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_error_o;

    modport slave (
        input  req_valid_i,
        output req_ready_o,
        input  req_write_i,
        input  req_addr_i,
        input  req_size_i,
        input  req_wdata_i,
        output rsp_valid_o,
        input  rsp_ready_i,
        output rsp_rdata_o,
        output rsp_error_o
    );

    modport master (
        output req_valid_i,
        input  req_ready_o,
        output req_write_i,
        output req_addr_i,
        output req_size_i,
        output req_wdata_i,
        input  rsp_valid_o,
        output rsp_ready_i,
        input  rsp_rdata_o,
        input  rsp_error_o
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the rv32i core. Accepts one
// load/store at a time, performs byte/half/word accesses on an internal
// 2^ADDR_WIDTH-byte array of 32-bit words and answers after WAIT_CYCLES wait
// states.
// Ports:
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   bus        : dmem_responder_if.slave (request and response handshakes)
//   rd_count_o, wr_count_o, err_count_o : saturating 16-bit access counters,
//                present only when DMEM_STATS_EN is defined
// Optional feature macro: DMEM_STATS_EN
module dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dmem_responder_if.slave   bus
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]       rd_count_o,
    output logic [15:0]       wr_count_o,
    output logic [15:0]       err_count_o
`endif
);

    localparam int unsigned WordAw = ADDR_WIDTH - 2;
    localparam int unsigned Depth  = 1 << WordAw;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic req_ready;
    logic rsp_valid;
    logic accept;

    // Latched request
    logic                  write_q, write_d;
    logic [1:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  fault_q, fault_d;

    // Response registers
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [Depth];

    logic        req_fault;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        load_resp;
    logic [31:0] rd_word;
    logic [31:0] rd_shift;

    assign accept = bus.req_valid_i & req_ready;

    // Fault decode on the live request
    always_comb begin
        req_fault = 1'b0;
        case (bus.req_size_i)
            2'b00:   req_fault = 1'b0;
            2'b01:   req_fault = bus.req_addr_i[0];
            2'b10:   req_fault = |bus.req_addr_i[1:0];
            default: req_fault = 1'b1;
        endcase
        if ((bus.req_addr_i >> ADDR_WIDTH) != 32'd0) begin
            req_fault = 1'b1;
        end
    end

    // Byte-lane enables and lane-replicated store data
    always_comb begin
        mem_be    = 4'b0000;
        mem_wdata = bus.req_wdata_i;
        case (bus.req_size_i)
            2'b00: begin
                mem_be    = 4'b0001 << bus.req_addr_i[1:0];
                mem_wdata = {4{bus.req_wdata_i[7:0]}};
            end
            2'b01: begin
                mem_be    = bus.req_addr_i[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{bus.req_wdata_i[15:0]}};
            end
            2'b10:   mem_be = 4'b1111;
            default: mem_be = 4'b0000;
        endcase
    end

    // Reset suppresses a store presented in the same cycle
    assign mem_we = accept & bus.req_write_i & ~req_fault & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_be[k]) begin
                    mem_q[bus.req_addr_i[ADDR_WIDTH-1:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
                end
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM: next state. WAIT spans WAIT_CYCLES+1 cycles so that the response
    // rises 1+WAIT_CYCLES edges after acceptance, including WAIT_CYCLES=0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StWait;
                    cnt_d   = 4'(WAIT_CYCLES);
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (bus.rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            StIdle:  req_ready = 1'b1;
            StResp:  rsp_valid = 1'b1;
            default: begin
                req_ready = 1'b0;
                rsp_valid = 1'b0;
            end
        endcase
    end

    // The array read happens on the edge that enters RESP
    assign load_resp = (state_q == StWait) && (cnt_q == 4'd0);
    assign rd_word   = mem_q[addr_q[ADDR_WIDTH-1:2]];
    assign rd_shift  = rd_word >> {addr_q[1:0], 3'b000};

    always_comb begin
        write_d = write_q;
        size_d  = size_q;
        addr_d  = addr_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            write_d = bus.req_write_i;
            size_d  = bus.req_size_i;
            addr_d  = bus.req_addr_i[ADDR_WIDTH-1:0];
            fault_d = req_fault;
        end
        if (load_resp) begin
            err_d = fault_q;
            if (write_q || fault_q) begin
                rdata_d = 32'd0;
            end else begin
                case (size_q)
                    2'b00:   rdata_d = {24'd0, rd_shift[7:0]};
                    2'b01:   rdata_d = {16'd0, rd_shift[15:0]};
                    2'b10:   rdata_d = rd_word;
                    default: rdata_d = 32'd0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            write_q <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            fault_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            write_q <= write_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_error_o = err_q;

`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        err_cnt_d = err_cnt_q;
        if (accept) begin
            if (req_fault) begin
                if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            end else if (bus.req_write_i) begin
                if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
            end else begin
                if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_cnt_q  <= 16'd0;
            wr_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign rd_count_o  = rd_cnt_q;
    assign wr_count_o  = wr_cnt_q;
    assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected responses,
// monitors pop and compare on each response handshake.
module tb_dmem_responder;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t exp0_q[$];

    int m_rd = 0;
    int m_wr = 0;
    int m_err = 0;

    dmem_responder_if bus ();
    dmem_responder_if bus0 ();

`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt, wr_cnt, err_cnt;
    logic [15:0] rd_cnt0, wr_cnt0, err_cnt0;
`endif

    dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(1)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus)
`ifdef DMEM_STATS_EN
        ,
        .rd_count_o  (rd_cnt),
        .wr_count_o  (wr_cnt),
        .err_count_o (err_cnt)
`endif
    );

    dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) u_dut0 (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus0)
`ifdef DMEM_STATS_EN
        ,
        .rd_count_o  (rd_cnt0),
        .wr_count_o  (wr_cnt0),
        .err_count_o (err_cnt0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitors: a handshake sampled at negedge completes on the next posedge
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid_o && bus.rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check_eq("rsp_rdata", bus.rsp_rdata_o, e.rdata);
                check_eq("rsp_error", {31'd0, bus.rsp_error_o}, {31'd0, e.err});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus0.rsp_valid_o && bus0.rsp_ready_i) begin
            if (exp0_q.size() == 0) begin
                check_eq("unexpected_rsp0", 32'd1, 32'd0);
            end else begin
                rsp_t e;
                e = exp0_q.pop_front();
                check_eq("rsp0_rdata", bus0.rsp_rdata_o, e.rdata);
                check_eq("rsp0_error", {31'd0, bus0.rsp_error_o}, {31'd0, e.err});
            end
        end
    end

    task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                             input logic [31:0] wd);
        bus.req_valid_i = 1'b1;
        bus.req_write_i = wr;
        bus.req_addr_i  = addr;
        bus.req_size_i  = sz;
        bus.req_wdata_i = wd;
    endtask

    // Issue one request on the WAIT_CYCLES=1 instance and follow it to completion
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_er,
                         input bit hold);
        int k;
        rsp_t e;
        @(negedge clk);
        bus.rsp_ready_i = hold ? 1'b0 : 1'b1;
        k = 0;
        while (!bus.req_ready_o && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("req_ready_wait", {31'd0, bus.req_ready_o}, 32'd1);
        drive_req(wr, addr, sz, wd);
        e.rdata = exp_rd;
        e.err   = exp_er;
        exp_q.push_back(e);
        if (exp_er) m_err++;
        else if (wr) m_wr++;
        else m_rd++;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!bus.rsp_valid_o && k < 40);
        check_eq("latency", k, 32'd2);
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                check_eq("hold_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
                check_eq("hold_rdata", bus.rsp_rdata_o, exp_rd);
                check_eq("hold_error", {31'd0, bus.rsp_error_o}, {31'd0, exp_er});
                check_eq("hold_req_ready", {31'd0, bus.req_ready_o}, 32'd0);
                @(posedge clk);
                #1;
            end
            bus.rsp_ready_i = 1'b1;
        end
        @(posedge clk);
        #1;
        check_eq("post_hs_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        check_eq("post_hs_ready", {31'd0, bus.req_ready_o}, 32'd1);
    endtask

    // Word access on the WAIT_CYCLES=0 instance
    task automatic issue0(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd);
        int k;
        rsp_t e;
        @(negedge clk);
        bus0.req_valid_i = 1'b1;
        bus0.req_write_i = wr;
        bus0.req_addr_i  = addr;
        bus0.req_size_i  = 2'b10;
        bus0.req_wdata_i = wd;
        e.rdata = exp_rd;
        e.err   = 1'b0;
        exp0_q.push_back(e);
        @(posedge clk);
        #1;
        bus0.req_valid_i = 1'b0;
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!bus0.rsp_valid_o && k < 40);
        check_eq("latency0", k, 32'd1);
        @(posedge clk);
        #1;
        check_eq("post_hs0_ready", {31'd0, bus0.req_ready_o}, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid_i  = 1'b0;
        bus.req_write_i  = 1'b0;
        bus.req_addr_i   = 32'd0;
        bus.req_size_i   = 2'b00;
        bus.req_wdata_i  = 32'd0;
        bus.rsp_ready_i  = 1'b1;
        bus0.req_valid_i = 1'b0;
        bus0.req_write_i = 1'b0;
        bus0.req_addr_i  = 32'd0;
        bus0.req_size_i  = 2'b00;
        bus0.req_wdata_i = 32'd0;
        bus0.rsp_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_ready", {31'd0, bus.req_ready_o}, 32'd1);
        check_eq("rst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        check_eq("rst_rdata", bus.rsp_rdata_o, 32'd0);
        check_eq("rst_error", {31'd0, bus.rsp_error_o}, 32'd0);
        rst = 1'b0;

        // Word store/load, byte and half lane selection
        issue(1'b1, 32'h010, 2'b10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 32'h010, 2'b10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        issue(1'b1, 32'h013, 2'b00, 32'h000000AA, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 32'h010, 2'b10, 32'h0, 32'hAAADBEEF, 1'b0, 1'b0);
        issue(1'b0, 32'h012, 2'b01, 32'h0, 32'h0000AAAD, 1'b0, 1'b0);
        issue(1'b0, 32'h011, 2'b00, 32'h0, 32'h000000BE, 1'b0, 1'b0);

        // Misalignment faults leave contents untouched
        issue(1'b1, 32'h000, 2'b10, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 32'h002, 2'b10, 32'h0, 32'h0, 1'b1, 1'b0);
        issue(1'b1, 32'h001, 2'b01, 32'h00001234, 32'h0, 1'b1, 1'b0);
        issue(1'b0, 32'h000, 2'b10, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0);
        issue(1'b1, 32'h002, 2'b01, 32'hFFFFBEEF, 32'h0, 1'b0, 1'b0);
        issue(1'b0, 32'h000, 2'b10, 32'h0, 32'hBEEFF00D, 1'b0, 1'b0);
        issue(1'b0, 32'h002, 2'b01, 32'h0, 32'h0000BEEF, 1'b0, 1'b0);
        issue(1'b0, 32'h003, 2'b00, 32'h0, 32'h000000BE, 1'b0, 1'b0);
        // Out-of-range store must not alias onto address 0
        issue(1'b1, 32'h1000, 2'b00, 32'h000000FF, 32'h0, 1'b1, 1'b0);
        issue(1'b0, 32'h000, 2'b10, 32'h0, 32'hBEEFF00D, 1'b0, 1'b0);

        // Back-pressured response
        issue(1'b0, 32'h010, 2'b10, 32'h0, 32'hAAADBEEF, 1'b0, 1'b1);

        // Range and reserved-size faults
        issue(1'b0, 32'h1000, 2'b10, 32'h0, 32'h0, 1'b1, 1'b0);
        issue(1'b0, 32'h010, 2'b11, 32'h0, 32'h0, 1'b1, 1'b0);
        issue(1'b0, 32'hFFFFFFFC, 32'h2 == 32'h2 ? 2'b10 : 2'b10, 32'h0, 32'h0, 1'b1, 1'b0);
`ifdef DMEM_STATS_EN
        check_eq("rd_count", {16'd0, rd_cnt}, 32'(m_rd));
        check_eq("wr_count", {16'd0, wr_cnt}, 32'(m_wr));
        check_eq("err_count", {16'd0, err_cnt}, 32'(m_err));
`endif

        // Reset while in WAIT discards the load
        @(negedge clk);
        drive_req(1'b0, 32'h010, 2'b10, 32'h0);
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        check_eq("wait_req_ready", {31'd0, bus.req_ready_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_wait_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        check_eq("rst_wait_ready", {31'd0, bus.req_ready_o}, 32'd1);
        m_rd = 0;
        m_wr = 0;
        m_err = 0;

        // Reset coincident with a store: nothing written
        issue(1'b1, 32'h020, 2'b10, 32'h22222222, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive_req(1'b1, 32'h020, 2'b10, 32'h11111111);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.req_valid_i = 1'b0;
        check_eq("rst_same_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        check_eq("rst_same_ready", {31'd0, bus.req_ready_o}, 32'd1);
        m_rd = 0;
        m_wr = 0;
        m_err = 0;
        issue(1'b0, 32'h020, 2'b10, 32'h0, 32'h22222222, 1'b0, 1'b0);

        // Store survives a reset during its WAIT phase
        @(negedge clk);
        drive_req(1'b1, 32'h030, 2'b10, 32'h33333333);
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_st_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        m_rd = 0;
        m_wr = 0;
        m_err = 0;
        issue(1'b0, 32'h030, 2'b10, 32'h0, 32'h33333333, 1'b0, 1'b0);
`ifdef DMEM_STATS_EN
        check_eq("rd_count_after_rst", {16'd0, rd_cnt}, 32'(m_rd));
        check_eq("err_count_after_rst", {16'd0, err_cnt}, 32'(m_err));
`endif

        // Zero wait states
        issue0(1'b1, 32'h040, 32'h00000044, 32'h0);
        issue0(1'b0, 32'h040, 32'h0, 32'h00000044);

        repeat (3) @(posedge clk);
        #1;
        check_eq("sb_drain", exp_q.size(), 32'd0);
        check_eq("sb0_drain", exp0_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
